// File: rtl/acc_pkg.sv
// Shared constants and types for the accelerator memory read path.
package acc_pkg;

    localparam int unsigned MEM_AW = 16;
    localparam int unsigned MEM_DW = 64;
    localparam int unsigned LEN_W  = 4;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic {StIdle, StIssue} arb_state_e;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Request, memory and return-data bundle between the two matrix loaders and the arbiter.
interface mem_read_arbiter_if #(
    parameter int unsigned LEN_W = acc_pkg::LEN_W
);
    logic [1:0]                  req;
    logic [acc_pkg::MEM_AW-1:0]  addr0;
    logic [acc_pkg::MEM_AW-1:0]  addr1;
    logic [LEN_W-1:0]            len0;
    logic [LEN_W-1:0]            len1;
    logic [1:0]                  gnt;
    logic [acc_pkg::MEM_AW-1:0]  mem_addr;
    logic                        mem_read_enb;
    logic [acc_pkg::MEM_DW-1:0]  mem_data;
    logic [acc_pkg::MEM_DW-1:0]  rdata;
    logic [1:0]                  rvalid;
    logic                        rlast;
    logic                        busy;

    modport master (
        output req, addr0, addr1, len0, len1, mem_data,
        input  gnt, mem_addr, mem_read_enb, rdata, rvalid, rlast, busy
    );

    modport slave (
        input  req, addr0, addr1, len0, len1, mem_data,
        output gnt, mem_addr, mem_read_enb, rdata, rvalid, rlast, busy
    );

endinterface

// File: rtl/rd_ret_pipe.sv
// Return-data pipeline: tracks issued beats through the memory latency and captures the data.
module rd_ret_pipe #(
    parameter int unsigned LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic                       in_id,
    input  logic                       in_last,
    input  logic [acc_pkg::MEM_DW-1:0] mem_data,
    output logic [acc_pkg::MEM_DW-1:0] rdata,
    output logic [1:0]                 rvalid,
    output logic                       rlast,
    output logic                       busy
);
    import acc_pkg::*;

    logic [LAT-1:0]    v_q;
    logic [LAT-1:0]    id_q;
    logic [LAT-1:0]    last_q;
    logic [MEM_DW-1:0] rdata_q;
    logic [1:0]        rvalid_q;
    logic              rlast_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q      <= '0;
            id_q     <= '0;
            last_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            rlast_q  <= 1'b0;
        end else begin
            v_q[0]    <= in_valid;
            id_q[0]   <= in_id;
            last_q[0] <= in_last;
            for (int unsigned k = 1; k < LAT; k++) begin
                v_q[k]    <= v_q[k-1];
                id_q[k]   <= id_q[k-1];
                last_q[k] <= last_q[k-1];
            end
            // Tail stage lines up with the cycle the memory drives this beat's data.
            rvalid_q <= v_q[LAT-1] ? (id_q[LAT-1] ? 2'b10 : 2'b01) : 2'b00;
            rlast_q  <= v_q[LAT-1] & last_q[LAT-1];
            if (v_q[LAT-1]) begin
                rdata_q <= mem_data;
            end
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign rlast  = rlast_q;
    assign busy   = (|v_q) | (|rvalid_q);

endmodule

// File: rtl/mem_read_arbiter.sv
// Two-requester round-robin burst read arbiter with address generation and return steering.
module mem_read_arbiter #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned LEN_W = acc_pkg::LEN_W
) (
    input logic               clk,
    input logic               rst,
    mem_read_arbiter_if.slave bus
);
    import acc_pkg::*;

    arb_state_e        state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic              enb_q, enb_d;
    logic [LEN_W-1:0]  beat_q, beat_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_inc;
    logic              owner_q, owner_d;
    logic              rr_q, rr_d;

    logic [1:0]        elig;
    logic              last_beat, arb_en, win_valid, win_id;
    logic              issue_vld, ret_busy;
    logic [MEM_DW-1:0] rdata;
    logic [1:0]        rvalid;
    logic              rlast;

    // A requester holding gnt this cycle sits out the arbitration at the closing edge.
    always_comb begin
        last_beat = (beat_q == len_q);
        arb_en    = (state_q == StIdle) || last_beat;
        elig      = bus.req & ~gnt_q;
        win_valid = arb_en && (elig != 2'b00);
        if (elig == 2'b11) begin
            win_id = ~rr_q;
        end else if (elig[REQ_B]) begin
            win_id = REQ_B;
        end else begin
            win_id = REQ_A;
        end
    end

    always_comb begin
        state_d = StIdle;
        if (win_valid || ((state_q == StIssue) && !last_beat)) begin
            state_d = StIssue;
        end
    end

    always_comb begin
        gnt_d    = 2'b00;
        addr_d   = addr_q;
        base_d   = base_q;
        enb_d    = 1'b1;
        beat_d   = beat_q;
        len_d    = len_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        beat_inc = beat_q + LEN_W'(1);
        if (win_valid) begin
            gnt_d[win_id] = 1'b1;
            base_d        = (win_id == REQ_B) ? bus.addr1 : bus.addr0;
            addr_d        = (win_id == REQ_B) ? bus.addr1 : bus.addr0;
            len_d         = (win_id == REQ_B) ? bus.len1 : bus.len0;
            enb_d         = 1'b0;
            beat_d        = '0;
            owner_d       = win_id;
            rr_d          = win_id;
        end else if ((state_q == StIssue) && !last_beat) begin
            beat_d = beat_inc;
            addr_d = base_q + MEM_AW'(beat_inc);
            enb_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= 2'b00;
            addr_q  <= '0;
            base_q  <= '0;
            enb_q   <= 1'b1;
            beat_q  <= '0;
            len_q   <= '0;
            owner_q <= REQ_A;
            rr_q    <= REQ_B;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            enb_q   <= enb_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    assign issue_vld = (state_q == StIssue);

    rd_ret_pipe #(
        .LAT (LAT)
    ) u_ret (
        .clk      (clk),
        .rst      (rst),
        .in_valid (issue_vld),
        .in_id    (owner_q),
        .in_last  (last_beat),
        .mem_data (bus.mem_data),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rlast    (rlast),
        .busy     (ret_busy)
    );

    assign bus.gnt          = gnt_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_read_enb = enb_q;
    assign bus.rdata        = rdata;
    assign bus.rvalid       = rvalid;
    assign bus.rlast        = rlast;
    assign bus.busy         = issue_vld | ret_busy;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: LAT=1 and LAT=3 instances against a fixed-latency memory.
module tb_mem_read_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   nvec  = 0;
    int   nfail = 0;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.LEN_W(4)) bus1 ();
    mem_read_arbiter_if #(.LEN_W(4)) bus3 ();

    mem_read_arbiter #(.LAT(1), .LEN_W(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    mem_read_arbiter #(.LAT(3), .LEN_W(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    function automatic logic [63:0] pat(input logic [15:0] a);
        return {a, ~a, a ^ 16'hA5A5, 16'hC3C3};
    endfunction

    // Memory models: data for an address appears LAT cycles after the address.
    logic [15:0] a1_q;
    logic [15:0] a3_q [3];
    always @(posedge clk) begin
        a1_q    <= bus1.mem_addr;
        a3_q[0] <= bus3.mem_addr;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end
    assign bus1.mem_data = pat(a1_q);
    assign bus3.mem_data = pat(a3_q[2]);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bus1.req = 2'b00;
        bus3.req = 2'b00;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [86:0] obs, want;
        want = {2'b00, 16'h0000, 1'b1, 64'h0, 2'b00, 1'b0, 1'b0};
        obs = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rdata, bus1.rvalid,
               bus1.rlast, bus1.busy};
        nvec++;
        if (obs !== want) begin
            nfail++;
            $display("FAIL reset_lat1: got %h required %h", obs, want);
        end
        obs = {bus3.gnt, bus3.mem_addr, bus3.mem_read_enb, bus3.rdata, bus3.rvalid,
               bus3.rlast, bus3.busy};
        nvec++;
        if (obs !== want) begin
            nfail++;
            $display("FAIL reset_lat3: got %h required %h", obs, want);
        end
    endtask

    task automatic test_single_burst;
        logic [22:0] obs, want;
        do_reset;
        bus1.req = 2'b01; bus1.addr0 = 16'h0040; bus1.len0 = 4'd3;
        tick;
        bus1.req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            want = {(k == 0) ? 2'b01 : 2'b00, (k < 4) ? 16'h0040 + 16'(k) : 16'h0043,
                    1'(k >= 4), (k >= 2 && k <= 5) ? 2'b01 : 2'b00, 1'(k == 5), 1'(k <= 5)};
            obs = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid, bus1.rlast,
                   bus1.busy};
            nvec++;
            if (obs !== want) begin
                nfail++;
                $display("FAIL single_burst c%0d gnt/addr/enb/rvalid/rlast/busy: got %h required %h",
                         k, obs, want);
            end
            if (k >= 2 && k <= 5) begin
                nvec++;
                if (bus1.rdata !== pat(16'h0040 + 16'(k - 2))) begin
                    nfail++;
                    $display("FAIL single_burst c%0d rdata: got %h required %h", k, bus1.rdata,
                             pat(16'h0040 + 16'(k - 2)));
                end
            end
            tick;
        end
    endtask

    task automatic test_contention;
        logic [21:0] obs, want;
        logic [15:0] a;
        do_reset;
        bus1.addr0 = 16'h0100; bus1.addr1 = 16'h0200; bus1.len0 = 4'd0; bus1.len1 = 4'd0;
        bus1.req = 2'b11;
        tick;
        for (int k = 0; k < 6; k++) begin
            want = {(k % 2 == 0) ? 2'b01 : 2'b10, (k % 2 == 0) ? 16'h0100 : 16'h0200, 1'b0,
                    (k < 2) ? 2'b00 : ((k % 2 == 0) ? 2'b01 : 2'b10), 1'(k >= 2)};
            obs = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid, bus1.rlast};
            nvec++;
            if (obs !== want) begin
                nfail++;
                $display("FAIL contention c%0d gnt/addr/enb/rvalid/rlast: got %h required %h",
                         k, obs, want);
            end
            if (k >= 2) begin
                a = (k % 2 == 0) ? 16'h0100 : 16'h0200;
                nvec++;
                if (bus1.rdata !== pat(a)) begin
                    nfail++;
                    $display("FAIL contention c%0d rdata: got %h required %h", k, bus1.rdata,
                             pat(a));
                end
            end
            tick;
        end
        bus1.req = 2'b00;
        repeat (4) tick;
    endtask

    task automatic test_wrap;
        logic [21:0] obs, want;
        do_reset;
        bus1.req = 2'b10; bus1.addr1 = 16'hFFFE; bus1.len1 = 4'd3;
        tick;
        bus1.req = 2'b00;
        for (int k = 0; k < 6; k++) begin
            want = {(k == 0) ? 2'b10 : 2'b00, (k < 4) ? 16'hFFFE + 16'(k) : 16'h0001,
                    1'(k >= 4), (k >= 2) ? 2'b10 : 2'b00, 1'(k == 5)};
            obs = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid, bus1.rlast};
            nvec++;
            if (obs !== want) begin
                nfail++;
                $display("FAIL wrap c%0d gnt/addr/enb/rvalid/rlast: got %h required %h",
                         k, obs, want);
            end
            if (k >= 2) begin
                nvec++;
                if (bus1.rdata !== pat(16'hFFFE + 16'(k - 2))) begin
                    nfail++;
                    $display("FAIL wrap c%0d rdata: got %h required %h", k, bus1.rdata,
                             pat(16'hFFFE + 16'(k - 2)));
                end
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [22:0] obs, want;
        logic [15:0] a;
        logic [1:0]  g, rv;
        do_reset;
        bus1.req = 2'b01; bus1.addr0 = 16'h1000; bus1.len0 = 4'd15;
        bus1.addr1 = 16'h2000; bus1.len1 = 4'd1;
        tick;
        bus1.req = 2'b00;
        for (int k = 0; k < 22; k++) begin
            g  = (k == 0) ? 2'b01 : ((k == 16) ? 2'b10 : 2'b00);
            a  = (k <= 15) ? 16'h1000 + 16'(k) : ((k == 16) ? 16'h2000 : 16'h2001);
            rv = (k >= 2 && k <= 17) ? 2'b01 : ((k == 18 || k == 19) ? 2'b10 : 2'b00);
            want = {g, a, 1'(k >= 18), rv, 1'(k == 17 || k == 19), 1'(k <= 19)};
            obs = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid, bus1.rlast,
                   bus1.busy};
            nvec++;
            if (obs !== want) begin
                nfail++;
                $display("FAIL back_to_back c%0d gnt/addr/enb/rvalid/rlast/busy: got %h required %h",
                         k, obs, want);
            end
            if (rv != 2'b00) begin
                a = (k <= 17) ? 16'h1000 + 16'(k - 2) : 16'h2000 + 16'(k - 18);
                nvec++;
                if (bus1.rdata !== pat(a)) begin
                    nfail++;
                    $display("FAIL back_to_back c%0d rdata: got %h required %h", k, bus1.rdata,
                             pat(a));
                end
            end
            if (k == 3) begin
                bus1.addr0 = 16'hDEAD; bus1.len0 = 4'd0;
            end
            if (k == 5) bus1.req = 2'b10;
            if (k == 16) bus1.req = 2'b00;
            tick;
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [21:0] obs, want;
        do_reset;
        bus1.req = 2'b01; bus1.addr0 = 16'h0300; bus1.len0 = 4'd7;
        tick;
        bus1.req = 2'b00;
        tick;
        tick;
        nvec++;
        if ({bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid} !== {16'h0302, 1'b0, 2'b01}) begin
            nfail++;
            $display("FAIL rst_mid pre addr/enb/rvalid: got %h required %h",
                     {bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid}, {16'h0302, 1'b0, 2'b01});
        end
        rst = 1'b1;
        #1;
        want = {2'b00, 16'h0000, 1'b1, 2'b00, 1'b0};
        obs  = {bus1.gnt, bus1.mem_addr, bus1.mem_read_enb, bus1.rvalid, bus1.rlast};
        nvec++;
        if (obs !== want || bus1.busy !== 1'b0) begin
            nfail++;
            $display("FAIL rst_mid async gnt/addr/enb/rvalid/rlast busy: got %h %b required %h 0",
                     obs, bus1.busy, want);
        end
        tick;
        tick;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            nvec++;
            if ({bus1.rvalid, bus1.mem_read_enb} !== 3'b001) begin
                nfail++;
                $display("FAIL rst_mid after c%0d rvalid/enb: got %b required 001", k,
                         {bus1.rvalid, bus1.mem_read_enb});
            end
        end
        bus1.len0 = 4'd0; bus1.len1 = 4'd0; bus1.addr1 = 16'h0400;
        bus1.req = 2'b11;
        tick;
        nvec++;
        if ({bus1.gnt, bus1.mem_addr} !== {2'b01, 16'h0300}) begin
            nfail++;
            $display("FAIL rst_mid next_grant gnt/addr: got %h required %h",
                     {bus1.gnt, bus1.mem_addr}, {2'b01, 16'h0300});
        end
        bus1.req = 2'b00;
        repeat (4) tick;
    endtask

    task automatic test_lat3;
        logic [22:0] obs, want;
        do_reset;
        bus3.req = 2'b01; bus3.addr0 = 16'h0500; bus3.len0 = 4'd1;
        tick;
        bus3.req = 2'b00;
        for (int k = 0; k < 8; k++) begin
            want = {(k == 0) ? 2'b01 : 2'b00, (k == 0) ? 16'h0500 : 16'h0501, 1'(k >= 2),
                    (k == 4 || k == 5) ? 2'b01 : 2'b00, 1'(k == 5), 1'(k <= 5)};
            obs = {bus3.gnt, bus3.mem_addr, bus3.mem_read_enb, bus3.rvalid, bus3.rlast,
                   bus3.busy};
            nvec++;
            if (obs !== want) begin
                nfail++;
                $display("FAIL lat3 c%0d gnt/addr/enb/rvalid/rlast/busy: got %h required %h",
                         k, obs, want);
            end
            if (k == 4 || k == 5) begin
                nvec++;
                if (bus3.rdata !== pat(16'h0500 + 16'(k - 4))) begin
                    nfail++;
                    $display("FAIL lat3 c%0d rdata: got %h required %h", k, bus3.rdata,
                             pat(16'h0500 + 16'(k - 4)));
                end
            end
            tick;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus1.req = 2'b00; bus1.addr0 = '0; bus1.addr1 = '0; bus1.len0 = '0; bus1.len1 = '0;
        bus3.req = 2'b00; bus3.addr0 = '0; bus3.addr1 = '0; bus3.len0 = '0; bus3.len1 = '0;
        #1;
        test_reset;
        tick;
        test_reset;
        rst = 1'b0;
        test_single_burst;
        test_contention;
        test_wrap;
        test_back_to_back;
        test_reset_mid_burst;
        test_lat3;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter: LAT, default 1, input-memory read latency in cycles (1..4).
REQ-002 Parameter: LEN_W, default 4, burst-length field width.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 req  in  2  per-requester read request, level; bit0 = matrix-1 loader, bit1 = matrix-2 loader.
REQ-006 addr0, addr1  in  16  burst base word address per requester.
REQ-007 len0, len1  in  LEN_W  burst length minus one (0 = 1 beat, 15 = 16 beats).
REQ-008 gnt  out  2  one-cycle grant pulse; one-hot or zero.
REQ-009 mem_addr  out  16  registered memory word address.
REQ-010 mem_read_enb  out  1  registered, active-low read strobe.
REQ-011 mem_data  in  64  memory read data.
REQ-012 rdata  out  64  registered return data.
REQ-013 rvalid  out  2  return-data valid, one-hot, steered to the owning requester.
REQ-014 rlast  out  1  high with the final beat of a burst.
REQ-015 busy  out  1  high while any burst is issuing or any beat is in flight.

Function
REQ-016 States: IDLE (no issue), ISSUE (one beat per cycle); data return runs in a separate pipeline, independent of state.
REQ-017 Arbitration at each edge where state is IDLE, or ISSUE with beat == len: the pending requester wins; if both are pending, the one not granted last wins (round-robin); after reset, requester 0 wins first.
REQ-018 A requester whose gnt is high in the current cycle is masked from the arbitration at the edge ending that cycle.
REQ-019 On a win at edge E: after E, gnt[i]=1 for one cycle, mem_addr=addr_i, mem_read_enb=0, beat=0, len_i latched, state=ISSUE.
REQ-020 In ISSUE, each subsequent cycle: beat+1, mem_addr = base+beat mod 2^16 (wraps 0xFFFF->0x0000), mem_read_enb=0.
REQ-021 After the beat == len cycle: with no winner, state=IDLE and mem_read_enb=1 (mem_addr holds); with a winner, the new burst's first beat issues in the next cycle, with no bubble.
REQ-022 Data return: a beat issued in cycle C is sampled from mem_data at the end of cycle C+LAT; rdata/rvalid[i] are presented in cycle C+LAT+1, so latency from gnt to first rvalid is LAT+1 cycles.
REQ-023 rlast=1 exactly on the beat whose index == latched len; beats return in issue order.
REQ-024 req changes during ISSUE do not affect the current burst; addr/len are sampled only at grant.
REQ-025 busy = (state==ISSUE) OR any return-pipeline stage valid.
REQ-026 rvalid=0 implies rlast=0; rdata holds its last value when not valid.

Reset
REQ-027 On rst (asynchronous): state=IDLE, gnt=0, mem_addr=0, mem_read_enb=1, rdata=0, rvalid=0, rlast=0, busy=0, round-robin pointer=favour requester 0.
REQ-028 rst mid-burst clears all return-pipeline stages; in-flight beats never produce rvalid.

Structure
REQ-029 Shared package acc_pkg: MEM_AW=16, MEM_DW=64, LEN_W=4, requester-ID constants REQ_A=0, REQ_B=1.
REQ-030 One sub-module, rd_ret_pipe: an LAT-deep shift register of {valid, id, last} followed by the data capture register.
REQ-031 Arbiter FSM, beat counter and address generator live in mem_read_arbiter; target is 120-400 RTL lines.

Verification
REQ-032 Single burst: req=01, addr0=0x0040, len0=3, LAT=1 -> gnt=01 for one cycle; mem_addr 0x40..0x43 on 4 consecutive cycles with mem_read_enb=0; rvalid=01 on 4 beats starting 2 cycles after gnt; rlast on beat 3.
REQ-033 Contention: req=11 held, both len=0 -> grants alternate 01,10,01,10 on consecutive cycles with no issue bubble.
REQ-034 Wrap: addr1=0xFFFE, len1=3 -> mem_addr sequence FFFE, FFFF, 0000, 0001.
REQ-035 Back-to-back: requester 0 len=15, requester 1 raises req mid-burst -> requester 1's first beat issues the cycle after requester 0's beat 15; rvalid switches 01->10 with no gap.
REQ-036 Reset mid-burst: rst asserted at beat 2 of a len=7 burst -> mem_read_enb=1 and rvalid=0 immediately; no rvalid after rst deasserts; next grant goes to requester 0.
REQ-037 LAT=3 build: single 2-beat burst -> first rvalid exactly 4 cycles after gnt; busy falls the cycle after rlast.
